// File: rtl/fwd_track_pipe.sv
// ---------------------------------------------------------------------------
// fwd_track_pipe
//
// Producer side of the forwarding interface. Each instruction leaving EX is
// tracked through N_STAGES post-issue slots (slot 0 = youngest). Each slot is
// published to the forwarding unit. The oldest slot retires to the register
// file write port. A load-use stall from the forwarding unit inserts a bubble
// into slot 0 while the older slots keep moving.
//
// data_fwd_o is a flattened vector. Slot i occupies bits
// [i*FWD_W +: FWD_W], and each slot is laid out MSB first as:
//   {valid, rf_wr_en, mem_read, rd[4:0], rd_data[XLEN-1:0]}
//
// Ports
//   clk_i              clock, all state updates on the rising edge
//   rst_i              synchronous active-high reset
//   issue_valid_i      an instruction leaves EX this cycle
//   issue_ready_o      slot 0 accepts an issue this cycle
//   issue_rd_i         destination register
//   issue_rf_wr_en_i   instruction writes the register file
//   issue_mem_read_i   instruction is a load
//   ex_result_i        ALU result (ignored for loads)
//   mem_rdata_i        load data for the entry in slot MEM_READ_STAGE-1
//   hold_i             memory/pipeline freeze
//   flush_i            kills the presented issue (and slot 0 while held)
//   load_use_stall_ai  load-use stall from the forwarding unit
//   data_fwd_o         per-slot forwarding entries, flattened
//   wb_valid_o         register file write strobe
//   wb_rd_o            register file write address
//   wb_data_o          register file write data
//   bubble_cnt_o       saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module fwd_track_pipe #(
    parameter int N_STAGES       = 2,
    parameter int MEM_READ_STAGE = 1,
    parameter int CNT_W          = 16,
    parameter int XLEN           = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           issue_valid_i,
    output logic                           issue_ready_o,
    input  logic [4:0]                     issue_rd_i,
    input  logic                           issue_rf_wr_en_i,
    input  logic                           issue_mem_read_i,
    input  logic [XLEN-1:0]                ex_result_i,
    input  logic [XLEN-1:0]                mem_rdata_i,
    input  logic                           hold_i,
    input  logic                           flush_i,
    input  logic                           load_use_stall_ai,
    output logic [N_STAGES*(XLEN+8)-1:0]   data_fwd_o,
    output logic                           wb_valid_o,
    output logic [4:0]                     wb_rd_o,
    output logic [XLEN-1:0]                wb_data_o,
    output logic [CNT_W-1:0]               bubble_cnt_o
);

    localparam int FWD_W = XLEN + 8;

    typedef struct packed {
        logic            valid;
        logic            rf_wr_en;
        logic            mem_read;
        logic [4:0]      rd;
        logic [XLEN-1:0] rd_data;
    } data_fwd_t;

    data_fwd_t        r_slot [N_STAGES];
    logic [CNT_W-1:0] r_bubble_cnt;

    logic      w_advance;
    logic      w_issue_ready;
    logic      w_accept;
    data_fwd_t w_issue_entry;

    // hold freezes everything. Flush and load-use stall only block the issue.
    assign w_advance     = !hold_i;
    assign w_issue_ready = !rst_i && !hold_i && !load_use_stall_ai && !flush_i;
    assign w_accept      = issue_valid_i && w_issue_ready;

    // Entry captured into slot 0. A rejected issue becomes an all-zero bubble.
    always_comb begin
        // NOTE: default every field first so no path leaves a value unassigned (no latch).
        w_issue_entry = '0;
        if (w_accept) begin
            w_issue_entry.valid    = 1'b1;
            // x0 is never written or forwarded, so its write enable is dropped here.
            w_issue_entry.rf_wr_en = issue_rf_wr_en_i && (issue_rd_i != 5'd0);
            w_issue_entry.mem_read = issue_mem_read_i;
            w_issue_entry.rd       = issue_rd_i;
            w_issue_entry.rd_data  = ex_result_i;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every slot samples its predecessor's pre-edge value.
        if (rst_i) begin
            for (int i = 0; i < N_STAGES; i++) begin
                r_slot[i] <= '0;
            end
            r_bubble_cnt <= '0;
        end else if (w_advance) begin
            r_slot[0] <= w_issue_entry;
            for (int i = 1; i < N_STAGES; i++) begin
                r_slot[i] <= r_slot[i-1];
                // Load data joins the entry as it crosses into MEM_READ_STAGE.
                // From there on every slot carries final data.
                if (i == MEM_READ_STAGE && r_slot[i-1].valid && r_slot[i-1].mem_read) begin
                    r_slot[i].rd_data <= mem_rdata_i;
                end
            end
            // A flush outranks the stall, so only a real stall bubble is counted.
            if (load_use_stall_ai && !flush_i && !(&r_bubble_cnt)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end else if (flush_i) begin
            // Under hold only slot 0 is killed. Older slots stay frozen.
            r_slot[0].valid <= 1'b0;
        end
    end

    for (genvar g = 0; g < N_STAGES; g++) begin : g_fwd
        assign data_fwd_o[g*FWD_W +: FWD_W] = r_slot[g];
    end

    assign issue_ready_o = w_issue_ready;
    // Retirement happens only on an advancing edge, so a held entry retires exactly once.
    assign wb_valid_o    = !rst_i && w_advance && r_slot[N_STAGES-1].valid
                           && r_slot[N_STAGES-1].rf_wr_en;
    assign wb_rd_o       = r_slot[N_STAGES-1].rd;
    assign wb_data_o     = r_slot[N_STAGES-1].rd_data;
    assign bubble_cnt_o  = r_bubble_cnt;

endmodule

// File: tb/tb_fwd_track_pipe.sv
// ---------------------------------------------------------------------------
// tb_fwd_track_pipe
//
// Directed stimulus for fwd_track_pipe (N_STAGES=2, MEM_READ_STAGE=1).
// Each write-back the stimulus expects is queued when the instruction issues.
// A monitor on the falling edge pops and compares an entry whenever
// wb_valid_o is high. Slot contents, ready and the bubble counter are checked
// inline against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_fwd_track_pipe;

    localparam int N_STAGES = 2;
    localparam int CNT_W    = 16;
    localparam int XLEN     = 32;
    localparam int FWD_W    = XLEN + 8;

    logic                         clk_i = 1'b0;
    logic                         rst_i;
    logic                         issue_valid_i;
    logic                         issue_ready_o;
    logic [4:0]                   issue_rd_i;
    logic                         issue_rf_wr_en_i;
    logic                         issue_mem_read_i;
    logic [XLEN-1:0]              ex_result_i;
    logic [XLEN-1:0]              mem_rdata_i;
    logic                         hold_i;
    logic                         flush_i;
    logic                         load_use_stall_ai;
    logic [N_STAGES*FWD_W-1:0]    data_fwd_o;
    logic                         wb_valid_o;
    logic [4:0]                   wb_rd_o;
    logic [XLEN-1:0]              wb_data_o;
    logic [CNT_W-1:0]             bubble_cnt_o;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int      n_checks = 0;
    int      n_errors = 0;

    fwd_track_pipe #(
        .N_STAGES       (N_STAGES),
        .MEM_READ_STAGE (1),
        .CNT_W          (CNT_W),
        .XLEN           (XLEN)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .issue_valid_i     (issue_valid_i),
        .issue_ready_o     (issue_ready_o),
        .issue_rd_i        (issue_rd_i),
        .issue_rf_wr_en_i  (issue_rf_wr_en_i),
        .issue_mem_read_i  (issue_mem_read_i),
        .ex_result_i       (ex_result_i),
        .mem_rdata_i       (mem_rdata_i),
        .hold_i            (hold_i),
        .flush_i           (flush_i),
        .load_use_stall_ai (load_use_stall_ai),
        .data_fwd_o        (data_fwd_o),
        .wb_valid_o        (wb_valid_o),
        .wb_rd_o           (wb_rd_o),
        .wb_data_o         (wb_data_o),
        .bubble_cnt_o      (bubble_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write-back monitor. wb_* is combinational, so it is sampled mid-cycle.
    always @(negedge clk_i) begin
        if (wb_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL wb_unexpected: got rd=%0d data=0x%0h expected no write-back",
                         wb_rd_o, wb_data_o);
            end else begin
                wb_exp_t e;
                e = exp_q.pop_front();
                check("wb_rd", 64'(wb_rd_o), 64'(e.rd));
                check("wb_data", 64'(wb_data_o), 64'(e.data));
            end
        end
    end

    function automatic logic [FWD_W-1:0] slot_of(input int i);
        return data_fwd_o[i*FWD_W +: FWD_W];
    endfunction

    function automatic logic slot_valid(input int i);
        return data_fwd_o[i*FWD_W + FWD_W - 1];
    endfunction

    function automatic logic [FWD_W-1:0] mk(input logic wr, input logic mr,
                                            input logic [4:0] rd, input logic [XLEN-1:0] d);
        return {1'b1, wr, mr, rd, d};
    endfunction

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle;
        issue_valid_i    = 1'b0;
        issue_rd_i       = 5'd0;
        issue_rf_wr_en_i = 1'b0;
        issue_mem_read_i = 1'b0;
        ex_result_i      = '0;
    endtask

    task automatic present(input logic [4:0] rd, input logic wr, input logic mr,
                           input logic [XLEN-1:0] res);
        issue_valid_i    = 1'b1;
        issue_rd_i       = rd;
        issue_rf_wr_en_i = wr;
        issue_mem_read_i = mr;
        ex_result_i      = res;
    endtask

    task automatic expect_wb(input logic [4:0] rd, input logic [XLEN-1:0] d);
        wb_exp_t e;
        e.rd   = rd;
        e.data = d;
        exp_q.push_back(e);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i             = 1'b1;
        hold_i            = 1'b0;
        flush_i           = 1'b0;
        load_use_stall_ai = 1'b0;
        mem_rdata_i       = '0;
        idle();

        // Reset
        tick();
        check("rst_ready", 64'(issue_ready_o), 64'd0);
        check("rst_wb", 64'(wb_valid_o), 64'd0);
        tick();
        rst_i = 1'b0;
        #1;
        check("rst_slot0", 64'(slot_of(0)), 64'd0);
        check("rst_slot1", 64'(slot_of(1)), 64'd0);
        check("rst_bubble", 64'(bubble_cnt_o), 64'd0);
        check("ready_idle", 64'(issue_ready_o), 64'd1);

        // 1: ADD x5 = 0x10
        present(5'd5, 1'b1, 1'b0, 32'h10);
        expect_wb(5'd5, 32'h10);
        tick();
        idle();
        check("t1_slot0", 64'(slot_of(0)), 64'(mk(1'b1, 1'b0, 5'd5, 32'h10)));
        tick();
        check("t1_slot1", 64'(slot_of(1)), 64'(mk(1'b1, 1'b0, 5'd5, 32'h10)));
        check("t1_slot0_bubble", 64'(slot_valid(0)), 64'd0);
        check("t1_wb_valid", 64'(wb_valid_o), 64'd1);
        tick();

        // 2: load x7, data arrives during slot-0 residency
        present(5'd7, 1'b1, 1'b1, 32'h1234);
        expect_wb(5'd7, 32'hDEAD);
        tick();
        idle();
        mem_rdata_i = 32'hDEAD;
        tick();
        mem_rdata_i = '0;
        check("t2_slot1", 64'(slot_of(1)), 64'(mk(1'b1, 1'b1, 5'd7, 32'hDEAD)));
        tick();

        // 3: one-cycle load-use stall behind load x8
        present(5'd8, 1'b1, 1'b1, 32'h0);
        expect_wb(5'd8, 32'hBEEF);
        tick();
        present(5'd9, 1'b1, 1'b0, 32'h99);
        load_use_stall_ai = 1'b1;
        mem_rdata_i       = 32'hBEEF;
        #1;
        check("t3_ready_stall", 64'(issue_ready_o), 64'd0);
        tick();
        load_use_stall_ai = 1'b0;
        mem_rdata_i       = '0;
        check("t3_slot0_bubble", 64'(slot_valid(0)), 64'd0);
        check("t3_slot1_load", 64'(slot_of(1)), 64'(mk(1'b1, 1'b1, 5'd8, 32'hBEEF)));
        check("t3_bubble_cnt", 64'(bubble_cnt_o), 64'd1);
        expect_wb(5'd9, 32'h99);
        tick();
        idle();
        tick();
        tick();

        // 4: hold 3 cycles with ADD x3 in slot 1; a stall under hold is not counted
        present(5'd3, 1'b1, 1'b0, 32'h33);
        expect_wb(5'd3, 32'h33);
        tick();
        idle();
        tick();
        for (int c = 0; c < 3; c++) begin
            hold_i            = 1'b1;
            load_use_stall_ai = 1'b1;
            present(5'd4, 1'b1, 1'b0, 32'h44);
            #1;
            check("t4_wb_held", 64'(wb_valid_o), 64'd0);
            check("t4_ready_held", 64'(issue_ready_o), 64'd0);
            tick();
            check("t4_slot1_frozen", 64'(slot_of(1)), 64'(mk(1'b1, 1'b0, 5'd3, 32'h33)));
            check("t4_slot0_frozen", 64'(slot_valid(0)), 64'd0);
            check("t4_bubble_frozen", 64'(bubble_cnt_o), 64'd1);
        end
        hold_i            = 1'b0;
        load_use_stall_ai = 1'b0;
        idle();
        #1;
        check("t4_wb_release", 64'(wb_valid_o), 64'd1);
        tick();
        check("t4_slot1_drained", 64'(slot_valid(1)), 64'd0);

        // 5a: rd = x0 never writes
        present(5'd0, 1'b1, 1'b0, 32'h55);
        tick();
        idle();
        check("t5_x0_slot0", 64'(slot_of(0)), 64'(mk(1'b0, 1'b0, 5'd0, 32'h55)));
        tick();
        check("t5_x0_no_wb", 64'(wb_valid_o), 64'd0);

        // 5b: flush drops the presented issue, older slot 0 moves on unchanged
        present(5'd10, 1'b1, 1'b0, 32'hA0);
        expect_wb(5'd10, 32'hA0);
        tick();
        present(5'd11, 1'b1, 1'b0, 32'hB0);
        flush_i = 1'b1;
        #1;
        check("t5_ready_flush", 64'(issue_ready_o), 64'd0);
        tick();
        flush_i = 1'b0;
        idle();
        check("t5_flush_slot0", 64'(slot_valid(0)), 64'd0);
        check("t5_flush_slot1", 64'(slot_of(1)), 64'(mk(1'b1, 1'b0, 5'd10, 32'hA0)));
        tick();

        // 5c: flush under hold kills only slot 0
        present(5'd13, 1'b1, 1'b0, 32'hD0);
        expect_wb(5'd13, 32'hD0);
        tick();
        present(5'd12, 1'b1, 1'b0, 32'hC0);
        tick();
        idle();
        hold_i  = 1'b1;
        flush_i = 1'b1;
        tick();
        hold_i  = 1'b0;
        flush_i = 1'b0;
        check("t5_hflush_slot0", 64'(slot_valid(0)), 64'd0);
        check("t5_hflush_slot1", 64'(slot_of(1)), 64'(mk(1'b1, 1'b0, 5'd13, 32'hD0)));
        tick();
        tick();

        // 6a: reset with two valid slots; nothing retires
        present(5'd14, 1'b1, 1'b0, 32'hE0);
        tick();
        present(5'd15, 1'b1, 1'b0, 32'hF0);
        tick();
        idle();
        rst_i = 1'b1;
        #1;
        check("t6_wb_in_reset", 64'(wb_valid_o), 64'd0);
        tick();
        rst_i = 1'b0;
        check("t6_slot0_reset", 64'(slot_valid(0)), 64'd0);
        check("t6_slot1_reset", 64'(slot_valid(1)), 64'd0);

        // 6b: bubble counter saturation
        load_use_stall_ai = 1'b1;
        for (int c = 0; c < 65534; c++) tick();
        check("t6_bubble_fffe", 64'(bubble_cnt_o), 64'hFFFE);
        for (int c = 0; c < 3; c++) tick();
        check("t6_bubble_sat", 64'(bubble_cnt_o), 64'hFFFF);
        load_use_stall_ai = 1'b0;
        tick();
        tick();

        check("wb_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
